fetch_unit: RTL and testbench

Instruction fetch stage of the 32-bit RISC CPU. It sits directly upstream of the controller and datapath. It owns the PC register and issues requests to a variable-latency instruction memory. It presents the fetched instruction (op = instr[31:26], funct = instr[5:0]) with a valid flag. It consumes the controller's pcsrc and jump decisions, plus datapath targets, to form the next PC when the current instruction retires.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_unit_pc_next_mux.sv | 51 +++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the 32-bit RISC CPU front end.
//               Holds the fetch FSM state type, the jump-select encoding
//               driven by the controller, and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Fetch stage states: RST is a one-cycle landing state after reset so
  // the first request is raised on the cycle after reset release.
  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  // Controller jump select; 2'b11 is reserved and behaves like JMP_SEQ.
  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_ABS = 2'b01;
  localparam logic [1:0] JMP_REG = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_unit_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_mux
// Description : Combinational next-PC selection for the fetch stage.
//               Priority: absolute jump, register jump, taken branch,
//               sequential. Register and branch targets are word aligned
//               by clearing their two low bits.
// Ports       : pcplus4       in  n   sequential successor of pc
//               instr_index   in  26  instr[25:0], J/JAL word index
//               jump          in  2   jump select (see cpu_pkg)
//               pcsrc         in  1   branch taken
//               branch_target in  n   branch destination
//               jr_target     in  n   register destination for JR
//               next_pc       out n   selected next PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] pcplus4,
  input  logic [25:0]  instr_index,
  input  logic [1:0]   jump,
  input  logic         pcsrc,
  input  logic [n-1:0] branch_target,
  input  logic [n-1:0] jr_target,
  output logic [n-1:0] next_pc
);

  localparam logic [n-1:0] ALIGN_MASK  = ~n'(3);
  // Absolute jumps keep the 256 MiB region of the sequential successor.
  localparam logic [n-1:0] REGION_MASK = ~n'(32'h0FFF_FFFF);

  logic [n-1:0] abs_target;

  assign abs_target = (pcplus4 & REGION_MASK) | n'({instr_index, 2'b00});

  always_comb begin
    next_pc = pcplus4;
    if (jump == JMP_ABS) begin
      next_pc = abs_target;
    end else if (jump == JMP_REG) begin
      next_pc = jr_target & ALIGN_MASK;
    end else if (pcsrc) begin
      next_pc = branch_target & ALIGN_MASK;
    end
  end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, requests instructions
//               from a variable-latency memory, holds the fetched word for
//               the controller/datapath and advances the PC on retire.
// Ports       : clk, reset (sync, active low)
//               imem_req/imem_addr out, imem_ready/imem_rdata in
//               instr/instr_valid out, retire in
//               pcsrc, jump, branch_target, jr_target in (next-PC inputs)
//               pc, pcplus4, instr_count out
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          n        = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr,
  output logic         instr_valid,
  input  logic         retire,
  input  logic         pcsrc,
  input  logic [1:0]   jump,
  input  logic [n-1:0] branch_target,
  input  logic [n-1:0] jr_target,
  output logic [n-1:0] pc,
  output logic [n-1:0] pcplus4,
  output logic [31:0]  instr_count
);

  localparam logic [n-1:0] PC_STEP = n'(4);

  fetch_state_t state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_count_q, instr_count_d;
  logic [n-1:0] next_pc;

  assign pc          = pc_q;
  assign pcplus4     = pc_q + PC_STEP;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign instr_count = instr_count_q;
  // Request and address come straight from registers, so they are stable
  // for as long as the memory keeps imem_ready low.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;

  pc_next_mux #(
    .n (n)
  ) u_pc_next_mux (
    .pcplus4       (pcplus4),
    .instr_index   (instr_q[25:0]),
    .jump          (jump),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .jr_target     (jr_target),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    instr_count_d = instr_count_q;
    unique case (state_q)
      RST: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (retire) begin
          pc_d          = next_pc;
          instr_valid_d = 1'b0;
          instr_count_d = instr_count_q + 32'd1;
          state_d       = FETCH;
        end
      end
      default: begin
        state_d = RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RST;
      pc_q          <= n'(RESET_PC);
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instr_count_q <= instr_count_d;
    end
  end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Two units share stimulus
//               (reset PC 0 and 0xFFFF_FFFC), plus a standalone pc_next_mux
//               driven from a vector table. A per-cycle reference model is
//               compared against both units every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        retire = 1'b0;
  logic        pcsrc = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic [31:0] branch_target = '0;
  logic [31:0] jr_target = '0;

  logic        req0, req1, vld0, vld1;
  logic [31:0] addr0, addr1, ins0, ins1, pc0, pc1, p40, p41, cnt0, cnt1;

  fetch_unit #(.n(32), .RESET_PC(32'h0000_0000)) u_dut0 (
    .clk(clk), .reset(reset), .imem_req(req0), .imem_addr(addr0),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(ins0),
    .instr_valid(vld0), .retire(retire), .pcsrc(pcsrc), .jump(jump),
    .branch_target(branch_target), .jr_target(jr_target), .pc(pc0),
    .pcplus4(p40), .instr_count(cnt0));

  fetch_unit #(.n(32), .RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(ins1),
    .instr_valid(vld1), .retire(retire), .pcsrc(pcsrc), .jump(jump),
    .branch_target(branch_target), .jr_target(jr_target), .pc(pc1),
    .pcplus4(p41), .instr_count(cnt1));

  // Standalone next-PC mux
  logic [31:0] mx_p4, mx_bt, mx_jr, mx_out;
  logic [25:0] mx_idx;
  logic [1:0]  mx_j;
  logic        mx_s;

  pc_next_mux #(.n(32)) u_mux (
    .pcplus4(mx_p4), .instr_index(mx_idx), .jump(mx_j), .pcsrc(mx_s),
    .branch_target(mx_bt), .jr_target(mx_jr), .next_pc(mx_out));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_rp [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  bit          m_started [2];
  bit          m_valid [2];
  logic [31:0] m_pc [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_count [2];

  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                           input logic [1:0] j, input logic s,
                                           input logic [31:0] bt, input logic [31:0] jr);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (j == 2'b01) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (j == 2'b10) return jr & ~32'd3;
    if (s)          return bt & ~32'd3;
    return seq;
  endfunction

  task automatic model_step(input int i);
    if (!reset) begin
      m_started[i] = 0; m_valid[i] = 0; m_pc[i] = m_rp[i];
      m_instr[i] = '0;  m_count[i] = '0;
    end else if (!m_started[i]) begin
      m_started[i] = 1;
    end else if (!m_valid[i]) begin
      if (imem_ready) begin
        m_instr[i] = imem_rdata;
        m_valid[i] = 1;
      end
    end else if (retire) begin
      m_pc[i]    = ref_next(m_pc[i], m_instr[i], jump, pcsrc, branch_target, jr_target);
      m_valid[i] = 0;
      m_count[i] = m_count[i] + 32'd1;
    end
  endtask

  task automatic cmp(input int i, input logic req, input logic [31:0] addr,
                     input logic [31:0] ins, input logic vld, input logic [31:0] pcv,
                     input logic [31:0] p4, input logic [31:0] cnt);
    logic exp_req;
    exp_req = m_started[i] && !m_valid[i];
    check($sformatf("u%0d imem_req", i), {31'b0, req}, {31'b0, exp_req});
    if (exp_req) check($sformatf("u%0d imem_addr", i), addr, m_pc[i]);
    check($sformatf("u%0d instr_valid", i), {31'b0, vld}, {31'b0, m_valid[i]});
    check($sformatf("u%0d instr", i), ins, m_instr[i]);
    check($sformatf("u%0d pc", i), pcv, m_pc[i]);
    check($sformatf("u%0d pcplus4", i), p4, m_pc[i] + 32'd4);
    check($sformatf("u%0d instr_count", i), cnt, m_count[i]);
  endtask

  // One clock: advance the model from the pre-edge inputs, then compare.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cmp(0, req0, addr0, ins0, vld0, pc0, p40, cnt0);
    cmp(1, req1, addr1, ins1, vld1, pc1, p41, cnt1);
  endtask

  // ---------------- mux vector table ----------------
  typedef struct {
    logic [31:0] p4;
    logic [25:0] idx;
    logic [1:0]  j;
    logic        s;
    logic [31:0] bt;
    logic [31:0] jr;
    logic [31:0] exp;
  } mux_vec_t;

  mux_vec_t vecs [9];

  initial begin
    vecs[0] = '{32'h0000_0014, 26'h0,       2'b00, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_0014};
    vecs[1] = '{32'h0000_0014, 26'h0,       2'b00, 1'b1, 32'h0000_0040, 32'h0,         32'h0000_0040};
    vecs[2] = '{32'h0000_0014, 26'h100,     2'b01, 1'b1, 32'h0000_0040, 32'h0,         32'h0000_0400};
    vecs[3] = '{32'h0000_0014, 26'h0,       2'b10, 1'b1, 32'h0000_0040, 32'h0000_1237, 32'h0000_1234};
    vecs[4] = '{32'h0000_0014, 26'h0,       2'b11, 1'b1, 32'h0000_0043, 32'h0,         32'h0000_0040};
    vecs[5] = '{32'h0000_0014, 26'h0,       2'b11, 1'b0, 32'h0000_0043, 32'h0,         32'h0000_0014};
    vecs[6] = '{32'hA000_0004, 26'h3FF_FFFF, 2'b01, 1'b0, 32'h0,         32'h0,         32'hAFFF_FFFC};
    vecs[7] = '{32'h0000_0008, 26'h0,       2'b00, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFC};
    vecs[8] = '{32'h0000_0008, 26'h0,       2'b10, 1'b0, 32'h0,         32'hFFFF_FFFE, 32'hFFFF_FFFC};

    for (int k = 0; k < 9; k++) begin
      mx_p4 = vecs[k].p4; mx_idx = vecs[k].idx; mx_j = vecs[k].j;
      mx_s  = vecs[k].s;  mx_bt  = vecs[k].bt;  mx_jr = vecs[k].jr;
      #1;
      check($sformatf("mux vec %0d", k), mx_out, vecs[k].exp);
    end

    // ---------------- reset: 3 cycles low with imem_ready high ----------
    reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (3) cycle();
    check("reset imem_req", {31'b0, req0}, 32'd0);
    check("reset instr_valid", {31'b0, vld0}, 32'd0);
    check("reset pc", pc0, 32'h0);
    reset = 1'b1;
    cycle();
    check("first req", {31'b0, req0}, 32'd1);
    check("first addr", addr0, 32'h0);
    cycle();
    check("first valid", {31'b0, vld0}, 32'd1);
    check("first instr", ins0, 32'hDEAD_BEEF);

    // ---------------- sequential fetch ----------------
    reset = 1'b0; cycle(); reset = 1'b1; cycle();
    retire = 1'b1; jump = 2'b00; pcsrc = 1'b0; imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seq addr %0d", k), addr0, 32'(4 * k));
      imem_rdata = 32'h0800_0100;
      cycle();
      cycle();
    end
    check("seq count", cnt0, 32'd4);

    // ---------------- branch, jump priority, JR alignment ----------------
    check("pc before branch", addr0, 32'h10);
    cycle();                            // capture at 0x10
    pcsrc = 1'b1; branch_target = 32'h40;
    cycle();
    check("branch target", addr0, 32'h40);
    cycle();
    jump = 2'b01;
    cycle();
    check("jump beats branch", addr0, 32'h400);
    cycle();
    jump = 2'b10; jr_target = 32'h0000_1237;
    cycle();
    check("jr aligned", addr0, 32'h1234);

    // ---------------- wait states ----------------
    jump = 2'b00; pcsrc = 1'b0; retire = 1'b0; imem_ready = 1'b0;
    imem_rdata = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("wait req %0d", k), {31'b0, req0}, 32'd1);
      check($sformatf("wait addr %0d", k), addr0, 32'h1234);
    end
    imem_ready = 1'b1;
    cycle();
    check("wait capture", ins0, 32'h1234_5678);

    // ---------------- reset during a wait ----------------
    retire = 1'b1;
    cycle();                            // retire -> fetch 0x1238
    retire = 1'b0; imem_ready = 1'b0;
    cycle();
    reset = 1'b0; imem_ready = 1'b1;
    cycle();
    check("midwait reset pc", pc0, 32'h0);
    check("midwait reset valid", {31'b0, vld0}, 32'd0);
    reset = 1'b1;
    cycle();
    check("refetch addr", addr0, 32'h0);

    // ---------------- wrap (unit 1) and stray inputs ----------------
    check("wrap start addr", addr1, 32'hFFFF_FFFC);
    check("wrap pcplus4", p41, 32'h0);
    imem_ready = 1'b0; retire = 1'b1;
    cycle();                            // stray retire in FETCH
    check("stray retire count", cnt1, 32'd0);
    check("stray retire pc", pc1, 32'hFFFF_FFFC);
    imem_ready = 1'b1; retire = 1'b0; imem_rdata = 32'hAAAA_0001;
    cycle();
    imem_rdata = 32'h5555_0002;
    cycle();                            // stray imem_ready in ISSUE
    check("stray ready instr", ins1, 32'hAAAA_0001);
    retire = 1'b1;
    cycle();
    check("wrap next addr", addr1, 32'h0);

    // ---------------- randomized run against the model ----------------
    for (int k = 0; k < 3000; k++) begin
      reset         = ($urandom_range(0, 63) != 0);
      imem_ready    = $urandom_range(0, 1);
      retire        = $urandom_range(0, 1);
      pcsrc         = $urandom_range(0, 1);
      jump          = 2'($urandom_range(0, 3));
      imem_rdata    = $urandom;
      branch_target = $urandom;
      jr_target     = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
